// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the byte-wide RAM sequencer.
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef enum logic {
        OwnerIf = 1'b0,
        OwnerLs = 1'b1
    } owner_t;

    localparam logic [1:0]  SizeByte = 2'b00;
    localparam logic [1:0]  SizeHalf = 2'b01;
    localparam logic [1:0]  SizeWord = 2'b10;

    localparam logic        ReadOp   = 1'b1;
    localparam logic        WriteOp  = 1'b0;

    localparam logic [31:0] ZeroWord = 32'h0000_0000;

    // Number of byte beats for an access size; the reserved code behaves as a word.
    function automatic logic [2:0] beats_for_size(input logic [1:0] size);
        logic [2:0] beats;
        case (size)
            SizeByte: beats = 3'd1;
            SizeHalf: beats = 3'd2;
            SizeWord: beats = 3'd4;
            default:  beats = 3'd4;
        endcase
        return beats;
    endfunction

endpackage

// File: rtl/mem_ctrl_beat_cnt.sv
// Beat counter for one RAM transaction: latches the beat count N at grant,
// counts cycles spent in RD/WR and flags the address and capture boundaries.
module mem_beat_cnt
    import mem_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       advance,
    input  logic [1:0] size,
    input  logic       force_word,
    output logic [2:0] cnt,
    output logic       more_addr,
    output logic       last_addr,
    output logic       last_cap
);

    logic [2:0] beats;

    // Restart at grant with a freshly decoded N, otherwise count active cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= 3'd0;
            beats <= 3'd1;
        end else if (start) begin
            cnt   <= 3'd0;
            beats <= force_word ? 3'd4 : beats_for_size(size);
        end else if (advance) begin
            cnt <= cnt + 3'd1;
        end
    end

    // cnt equals the index of the address being presented; capture trails it by one.
    always_comb begin
        more_addr = (cnt < (beats - 3'd1));
        last_addr = (cnt == (beats - 3'd1));
        last_cap  = (cnt == beats);
    end

endmodule

// File: rtl/mem_ctrl.sv
// Arbiter/sequencer for the single byte-wide RAM port shared by instruction
// fetch and load/store. Splits requests into byte beats and assembles
// little-endian words from the returned bytes.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic [31:0]       if_data,
    output logic              if_done,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [1:0]        ls_size,
    input  logic [31:0]       ls_addr,
    input  logic [31:0]       ls_wdata,
    output logic [31:0]       ls_rdata,
    output logic              ls_done,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    output logic              busy
);

    state_t     state;
    state_t     next_state;
    owner_t     owner;
    logic       grant;
    logic       grant_write;
    logic       capture;
    logic [2:0] cnt;
    logic       more_addr;
    logic       last_addr;
    logic       last_cap;
    logic [1:0] lane;
    logic [23:0] wdata_sh;
    logic [31:0] asm_word;
    logic [31:0] assembled;
    logic        unused_upper;

    assign unused_upper = ^{if_addr[31:ADDR_W], ls_addr[31:ADDR_W]};

    assign grant       = (state == IDLE) && (ls_req || if_req);
    assign grant_write = ls_req && ls_we;
    assign capture     = (state == RD) && (cnt != 3'd0);
    assign lane        = cnt[1:0] - 2'd1;

    mem_beat_cnt u_beat_cnt (
        .clk        (clk),
        .rst        (rst),
        .start      (grant),
        .advance    ((state == RD) || (state == WR)),
        .size       (ls_size),
        .force_word (!ls_req),
        .cnt        (cnt),
        .more_addr  (more_addr),
        .last_addr  (last_addr),
        .last_cap   (last_cap)
    );

    // State register; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state: LS beats IF in IDLE, no preemption once a transaction starts.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (ls_req) begin
                    next_state = ls_we ? WR : RD;
                end else if (if_req) begin
                    next_state = RD;
                end
            end
            RD:      if (last_cap)  next_state = DONE;
            WR:      if (last_addr) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Merge the byte returning this cycle into its lane of the word being built.
    always_comb begin
        assembled = asm_word;
        assembled[{lane, 3'b000} +: 8] = mem_din;
    end

    // Registered RAM port, data assembly and completion pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner    <= OwnerIf;
            mem_a    <= '0;
            mem_wr   <= ReadOp;
            mem_dout <= 8'h00;
            wdata_sh <= 24'h000000;
            asm_word <= ZeroWord;
            if_data  <= ZeroWord;
            ls_rdata <= ZeroWord;
            if_done  <= 1'b0;
            ls_done  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            if (grant) begin
                owner    <= ls_req ? OwnerLs : OwnerIf;
                mem_a    <= ls_req ? ls_addr[ADDR_W-1:0] : if_addr[ADDR_W-1:0];
                mem_wr   <= grant_write ? WriteOp : ReadOp;
                asm_word <= ZeroWord;
                if (grant_write) begin
                    mem_dout <= ls_wdata[7:0];
                    wdata_sh <= ls_wdata[31:8];
                end
            end

            if (state == RD) begin
                if (more_addr) begin
                    mem_a <= mem_a + ADDR_W'(1);
                end
                if (capture) begin
                    asm_word <= assembled;
                end
                if (last_cap) begin
                    if (owner == OwnerLs) begin
                        ls_rdata <= assembled;
                    end else begin
                        if_data <= assembled;
                    end
                end
            end

            if (state == WR) begin
                if (more_addr) begin
                    mem_a    <= mem_a + ADDR_W'(1);
                    mem_dout <= wdata_sh[7:0];
                    wdata_sh <= {8'h00, wdata_sh[23:8]};
                end
                if (last_addr) begin
                    mem_wr <= ReadOp;
                end
            end

            if_done <= (next_state == DONE) && (state != DONE) && (owner == OwnerIf);
            ls_done <= (next_state == DONE) && (state != DONE) && (owner == OwnerLs);
            busy    <= (next_state != IDLE);
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed testbench for mem_ctrl with a behavioural byte RAM that returns
// read data one cycle after the address is presented.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_data;
    logic        if_done;
    logic        ls_req;
    logic        ls_we;
    logic [1:0]  ls_size;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic [31:0] ls_rdata;
    logic        ls_done;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [16:0] mem_a;
    logic        mem_wr;
    logic        busy;

    logic [7:0]  ram [0:131071];
    logic        bd_we;
    logic [16:0] bd_addr;
    logic [7:0]  bd_data;
    int          wr_total = 0;

    int          checks = 0;
    int          failures = 0;
    int          cyc;
    int          w0;
    int          saw_done;
    logic [16:0] seen_a [1:4];

    always #5 clk = ~clk;

    mem_ctrl #(.ADDR_W(17)) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_data  (if_data),
        .if_done  (if_done),
        .ls_req   (ls_req),
        .ls_we    (ls_we),
        .ls_size  (ls_size),
        .ls_addr  (ls_addr),
        .ls_wdata (ls_wdata),
        .ls_rdata (ls_rdata),
        .ls_done  (ls_done),
        .mem_din  (mem_din),
        .mem_dout (mem_dout),
        .mem_a    (mem_a),
        .mem_wr   (mem_wr),
        .busy     (busy)
    );

    // Synchronous RAM: backdoor preload, writes when mem_wr is low, registered read.
    always @(posedge clk) begin
        if (bd_we) ram[bd_addr] <= bd_data;
        if (mem_wr == 1'b0) begin
            ram[mem_a] <= mem_dout;
            wr_total   <= wr_total + 1;
        end
        mem_din <= ram[mem_a];
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic ir, input logic [31:0] ia, input logic lr,
                                  input logic we, input logic [1:0] sz,
                                  input logic [31:0] la, input logic [31:0] wd);
        if_req   = ir;
        if_addr  = ia;
        ls_req   = lr;
        ls_we    = we;
        ls_size  = sz;
        ls_addr  = la;
        ls_wdata = wd;
    endtask

    task automatic poke(input logic [16:0] a, input logic [7:0] d);
        bd_addr = a;
        bd_data = d;
        bd_we   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bd_we   = 1'b0;
    endtask

    task automatic wait_done(input bit want_ls, input int max_cycles, output int found);
        found = -1;
        for (int k = 1; k <= max_cycles; k++) begin
            @(negedge clk);
            if ((want_ls ? ls_done : if_done) === 1'b1) begin
                found = k;
                break;
            end
        end
    endtask

    // Linear sequence of directed scenarios with hand-computed expectations.
    initial begin
        rst   = 1'b0;
        bd_we = 1'b0;
        bd_addr = '0;
        bd_data = '0;
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        #12;
        check_output("reset_mem_a",    32'(mem_a),    32'h0);
        check_output("reset_mem_wr",   32'(mem_wr),   32'h1);
        check_output("reset_mem_dout", 32'(mem_dout), 32'h0);
        check_output("reset_if_data",  if_data,       32'h0);
        check_output("reset_ls_rdata", ls_rdata,      32'h0);
        check_output("reset_dones",    {30'h0, if_done, ls_done}, 32'h0);
        check_output("reset_busy",     32'(busy),     32'h0);
        @(negedge clk);
        rst = 1'b1;

        poke(17'h00100, 8'h13); poke(17'h00101, 8'h05); poke(17'h00102, 8'h00); poke(17'h00103, 8'h00);
        poke(17'h00200, 8'hEF); poke(17'h00201, 8'hBE); poke(17'h00202, 8'hAD); poke(17'h00203, 8'hDE);
        poke(17'h00301, 8'h00); poke(17'h00302, 8'h00); poke(17'h00303, 8'h77);
        poke(17'h1FFFE, 8'h11); poke(17'h1FFFF, 8'h22); poke(17'h00000, 8'h33); poke(17'h00001, 8'h44);
        poke(17'h00400, 8'h00); poke(17'h00401, 8'h00); poke(17'h00402, 8'h00); poke(17'h00403, 8'h00);

        $display("[TB] IF-only word fetch");
        w0 = wr_total;
        apply_stimulus(1'b1, 32'h100, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        wait_done(1'b0, 10, cyc);
        check_output("if_fetch_latency", 32'(cyc), 32'd6);
        check_output("if_fetch_data",    if_data,  32'h0000_0513);
        check_output("if_fetch_no_wr",   32'(wr_total - w0), 32'd0);
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        @(negedge clk);
        check_output("if_done_one_cycle", 32'(if_done), 32'h0);
        check_output("if_idle_busy",      32'(busy),    32'h0);
        check_output("if_data_held",      if_data,      32'h0000_0513);

        $display("[TB] simultaneous IF and LS requests");
        apply_stimulus(1'b1, 32'h100, 1'b1, 1'b0, 2'b10, 32'h200, 32'h0);
        wait_done(1'b1, 10, cyc);
        check_output("arb_ls_latency", 32'(cyc), 32'd6);
        check_output("arb_ls_rdata",   ls_rdata, 32'hDEAD_BEEF);
        apply_stimulus(1'b1, 32'h100, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        @(negedge clk);
        check_output("arb_idle_gap", 32'(busy), 32'h0);
        @(negedge clk);
        check_output("arb_if_granted", 32'(busy),  32'h1);
        check_output("arb_if_addr",    32'(mem_a), 32'h100);
        wait_done(1'b0, 10, cyc);
        check_output("arb_if_latency", 32'(cyc), 32'd5);
        check_output("arb_if_data",    if_data,  32'h0000_0513);
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        @(negedge clk);

        $display("[TB] misaligned half store then byte load");
        w0 = wr_total;
        apply_stimulus(1'b0, 32'h0, 1'b1, 1'b1, 2'b01, 32'h301, 32'h1234_ABCD);
        wait_done(1'b1, 10, cyc);
        check_output("st_half_latency", 32'(cyc), 32'd3);
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        check_output("st_half_wr_count", 32'(wr_total - w0), 32'd2);
        check_output("st_half_byte0",    32'(ram[17'h00301]), 32'hCD);
        check_output("st_half_byte1",    32'(ram[17'h00302]), 32'hAB);
        check_output("st_half_untouched", 32'(ram[17'h00303]), 32'h77);
        @(negedge clk);
        apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0, 2'b00, 32'h302, 32'h0);
        wait_done(1'b1, 10, cyc);
        check_output("ld_byte_latency", 32'(cyc), 32'd3);
        check_output("ld_byte_rdata",   ls_rdata, 32'h0000_00AB);
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        @(negedge clk);

        $display("[TB] address wrap with upper bits set");
        apply_stimulus(1'b1, 32'h8001_FFFE, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            seen_a[k] = mem_a;
        end
        wait_done(1'b0, 10, cyc);
        check_output("wrap_a1", 32'(seen_a[1]), 32'h1FFFE);
        check_output("wrap_a2", 32'(seen_a[2]), 32'h1FFFF);
        check_output("wrap_a3", 32'(seen_a[3]), 32'h00000);
        check_output("wrap_a4", 32'(seen_a[4]), 32'h00001);
        check_output("wrap_latency", 32'(cyc), 32'd2);
        check_output("wrap_data",    if_data,  32'h4433_2211);
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        @(negedge clk);

        $display("[TB] reset during word store");
        w0 = wr_total;
        apply_stimulus(1'b0, 32'h0, 1'b1, 1'b1, 2'b10, 32'h400, 32'h5566_7788);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check_output("rst_mid_mem_wr", 32'(mem_wr), 32'h1);
        check_output("rst_mid_busy",   32'(busy),   32'h0);
        check_output("rst_mid_mem_a",  32'(mem_a),  32'h0);
        saw_done = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (ls_done === 1'b1) saw_done++;
        end
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        rst = 1'b1;
        check_output("rst_mid_no_done",  32'(saw_done), 32'd0);
        check_output("rst_mid_wr_count", 32'(wr_total - w0), 32'd2);
        check_output("rst_mid_byte0",    32'(ram[17'h00400]), 32'h88);
        check_output("rst_mid_byte1",    32'(ram[17'h00401]), 32'h77);
        check_output("rst_mid_byte2",    32'(ram[17'h00402]), 32'h00);
        check_output("rst_mid_rdata",    ls_rdata, 32'h0);

        $display("[TB] LS arriving during IF fetch");
        @(negedge clk);
        apply_stimulus(1'b1, 32'h100, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        check_output("nopre_if_addr", 32'(mem_a), 32'h101);
        apply_stimulus(1'b1, 32'h100, 1'b1, 1'b0, 2'b00, 32'h302, 32'h0);
        wait_done(1'b0, 10, cyc);
        check_output("nopre_if_latency", 32'(cyc), 32'd4);
        check_output("nopre_if_data",    if_data,  32'h0000_0513);
        apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0, 2'b00, 32'h302, 32'h0);
        wait_done(1'b1, 10, cyc);
        check_output("nopre_ls_latency", 32'(cyc), 32'd4);
        check_output("nopre_ls_rdata",   ls_rdata, 32'h0000_00AB);
        apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        @(negedge clk);
        check_output("final_idle", 32'(busy), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
